// File: rtl/xilly_hls_stream_bridge.sv
// xilly_hls_stream_bridge: Xillybus stream pair to HLS ap_fifo bridge with input/output buffering
module xilly_hls_stream_bridge #(
  parameter int DATA_W = 32,
  parameter int IN_AW  = 9,
  parameter int OUT_AW = 9,
  parameter bit EOF_EN = 1'b1
) (
  input  logic              bus_clk,
  input  logic              bus_rst_n,
  input  logic              user_w_wren,
  input  logic [DATA_W-1:0] user_w_data,
  input  logic              user_w_open,
  output logic              user_w_full,
  input  logic              user_r_rden,
  output logic [DATA_W-1:0] user_r_data,
  output logic              user_r_empty,
  output logic              user_r_eof,
  input  logic              user_r_open,
  output logic              hls_rst,
  input  logic              hls_idle,
  output logic [DATA_W-1:0] in_dout,
  output logic              in_empty_n,
  input  logic              in_read,
  input  logic [DATA_W-1:0] out_din,
  input  logic              out_write,
  output logic              out_full_n,
  output logic [IN_AW:0]    in_level,
  output logic [OUT_AW:0]   out_level,
  output logic              ovf_err
);

  localparam int IN_D  = 2 ** IN_AW;
  localparam int OUT_D = 2 ** OUT_AW;
  localparam logic [IN_AW:0]  IN_FULL  = {1'b1, {IN_AW{1'b0}}};
  localparam logic [OUT_AW:0] OUT_FULL = {1'b1, {OUT_AW{1'b0}}};

  logic [DATA_W-1:0] in_mem  [IN_D];
  logic [DATA_W-1:0] out_mem [OUT_D];

  logic [IN_AW-1:0]  in_wp_q, in_wp_d, in_rp_q, in_rp_d;
  logic [IN_AW:0]    in_lvl_q, in_lvl_d;
  logic [OUT_AW-1:0] out_wp_q, out_wp_d, out_rp_q, out_rp_d;
  logic [OUT_AW:0]   out_lvl_q, out_lvl_d;
  logic [DATA_W-1:0] stg_data_q, stg_data_d, rdata_q, rdata_d;
  logic              stg_v_q, stg_v_d;
  logic              ovf_q, ovf_d;
  logic              hls_rst_q, hls_rst_d;
  logic              wopen_q, wr_seen_q, wr_seen_d;
  logic              eof_q, eof_d;

  logic flush, in_push, in_pop, out_push, out_pop;

  // A closed session (neither file open) flushes every buffer and status bit
  assign flush    = !(user_w_open || user_r_open);
  assign in_push  = user_w_wren && !user_w_full;
  assign in_pop   = (in_lvl_q != '0) && (!stg_v_q || in_read);
  assign out_push = out_write && out_full_n;
  assign out_pop  = user_r_rden && !user_r_empty;

  assign user_w_full  = in_lvl_q == IN_FULL;
  assign out_full_n   = out_lvl_q != OUT_FULL;
  assign user_r_empty = out_lvl_q == '0;
  assign user_r_data  = rdata_q;
  assign user_r_eof   = eof_q;
  assign hls_rst      = hls_rst_q;
  assign in_dout      = stg_data_q;
  assign in_empty_n   = stg_v_q;
  assign in_level     = in_lvl_q;
  assign out_level    = out_lvl_q;
  assign ovf_err      = ovf_q;

  // Storage arrays are written without reset; validity comes from the pointers
  always_ff @(posedge bus_clk) begin
    if (in_push) in_mem[in_wp_q] <= user_w_data;
    if (out_push) out_mem[out_wp_q] <= out_din;
  end

  // Input FIFO pointers/level and the ap_fifo staging register
  always_comb begin
    in_wp_d    = flush ? '0 : in_push ? in_wp_q + IN_AW'(1) : in_wp_q;
    in_rp_d    = flush ? '0 : in_pop ? in_rp_q + IN_AW'(1) : in_rp_q;
    in_lvl_d   = flush ? '0 : in_lvl_q + (IN_AW+1)'(in_push) - (IN_AW+1)'(in_pop);
    stg_v_d    = flush ? 1'b0 : in_pop ? 1'b1 : stg_v_q && !in_read;
    stg_data_d = flush ? '0 : in_pop ? in_mem[in_rp_q] : stg_data_q;
  end

  // Output FIFO pointers/level and the registered host read word
  always_comb begin
    out_wp_d  = flush ? '0 : out_push ? out_wp_q + OUT_AW'(1) : out_wp_q;
    out_rp_d  = flush ? '0 : out_pop ? out_rp_q + OUT_AW'(1) : out_rp_q;
    out_lvl_d = flush ? '0 : out_lvl_q + (OUT_AW+1)'(out_push) - (OUT_AW+1)'(out_pop);
    rdata_d   = out_pop ? out_mem[out_rp_q] : rdata_q;
  end

  // Sticky overflow, core reset and end-of-stream detection
  always_comb begin
    ovf_d     = !flush && (ovf_q || (user_w_wren && user_w_full) || (out_write && !out_full_n));
    hls_rst_d = flush;
    wr_seen_d = !flush && (wr_seen_q || (user_w_open && !wopen_q));
    eof_d     = EOF_EN && !flush && wr_seen_q && !user_w_open && (in_lvl_q == '0) &&
                !stg_v_q && hls_idle && user_r_empty;
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      in_wp_q    <= '0;
      in_rp_q    <= '0;
      in_lvl_q   <= '0;
      out_wp_q   <= '0;
      out_rp_q   <= '0;
      out_lvl_q  <= '0;
      stg_v_q    <= 1'b0;
      stg_data_q <= '0;
      rdata_q    <= '0;
      ovf_q      <= 1'b0;
      hls_rst_q  <= 1'b1;
      wopen_q    <= 1'b0;
      wr_seen_q  <= 1'b0;
      eof_q      <= 1'b0;
    end else begin
      in_wp_q    <= in_wp_d;
      in_rp_q    <= in_rp_d;
      in_lvl_q   <= in_lvl_d;
      out_wp_q   <= out_wp_d;
      out_rp_q   <= out_rp_d;
      out_lvl_q  <= out_lvl_d;
      stg_v_q    <= stg_v_d;
      stg_data_q <= stg_data_d;
      rdata_q    <= rdata_d;
      ovf_q      <= ovf_d;
      hls_rst_q  <= hls_rst_d;
      wopen_q    <= user_w_open;
      wr_seen_q  <= wr_seen_d;
      eof_q      <= eof_d;
    end
  end

endmodule

// File: tb/tb_xilly_hls_stream_bridge.sv
// tb_xilly_hls_stream_bridge: scoreboard bench with queue reference model for the stream bridge
module tb_xilly_hls_stream_bridge;
  localparam int W = 32;
  localparam int AW = 9;
  localparam int D = 1 << AW;

  logic bus_clk = 0, bus_rst_n = 1;
  logic user_w_wren = 0, user_w_open = 0, user_r_rden = 0, user_r_open = 0, hls_idle = 0;
  logic [W-1:0] user_w_data = 0;
  logic user_w_full, user_r_empty, user_r_eof, hls_rst, in_empty_n, out_full_n, ovf_err;
  logic [W-1:0] user_r_data, in_dout, out_din;
  logic in_read, out_write;
  logic [AW:0] in_level, out_level;

  logic loop = 0, core_rd = 0, core_wr = 0;
  logic [W-1:0] core_din = 0;

  assign in_read   = core_rd;
  assign out_write = loop ? (in_empty_n && core_rd) : core_wr;
  assign out_din   = loop ? in_dout : core_din;

  xilly_hls_stream_bridge #(.DATA_W(W), .IN_AW(AW), .OUT_AW(AW), .EOF_EN(1'b1)) dut (
    .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
    .user_w_wren(user_w_wren), .user_w_data(user_w_data), .user_w_open(user_w_open),
    .user_w_full(user_w_full), .user_r_rden(user_r_rden), .user_r_data(user_r_data),
    .user_r_empty(user_r_empty), .user_r_eof(user_r_eof), .user_r_open(user_r_open),
    .hls_rst(hls_rst), .hls_idle(hls_idle), .in_dout(in_dout), .in_empty_n(in_empty_n),
    .in_read(in_read), .out_din(out_din), .out_write(out_write), .out_full_n(out_full_n),
    .in_level(in_level), .out_level(out_level), .ovf_err(ovf_err)
  );

  always #5 bus_clk = ~bus_clk;

  int total = 0, bad = 0;
  logic [W-1:0] exp_in[$], exp_out[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge bus_clk);
    #1;
  endtask

  // Monitor: compares every word the DUT hands to the core or to the host
  logic rd_pend = 0;
  always @(negedge bus_clk) begin
    if (!bus_rst_n) rd_pend = 0;
    else begin
      if (rd_pend) begin
        total++;
        if (exp_out.size() == 0) begin
          bad++;
          $display("FAIL rd_unexpected actual=%0h required=none", user_r_data);
        end else begin
          total--;
          chk("rd_data", user_r_data, exp_out.pop_front());
        end
      end
      rd_pend = user_r_rden && !user_r_empty;
      if (in_empty_n && core_rd) begin
        total++;
        if (exp_in.size() == 0) begin
          bad++;
          $display("FAIL in_unexpected actual=%0h required=none", in_dout);
        end else begin
          total--;
          chk("in_dout", in_dout, exp_in.pop_front());
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_empty_n"}, in_empty_n, 0);
    chk({tag, "_w_full"}, user_w_full, 0);
    chk({tag, "_r_empty"}, user_r_empty, 1);
    chk({tag, "_eof"}, user_r_eof, 0);
    chk({tag, "_hls_rst"}, hls_rst, 1);
    chk({tag, "_ovf"}, ovf_err, 0);
    chk({tag, "_in_level"}, in_level, 0);
    chk({tag, "_out_level"}, out_level, 0);
    chk({tag, "_r_data"}, user_r_data, 0);
    chk({tag, "_in_dout"}, in_dout, 0);
    chk({tag, "_out_full_n"}, out_full_n, 1);
  endtask

  task automatic drain_in();
    for (int i = 0; i < 3000 && exp_in.size() != 0; i++) tick();
    chk("drain_in_left", exp_in.size(), 0);
  endtask

  task automatic drain_out();
    user_r_rden = 1;
    for (int i = 0; i < 3000 && exp_out.size() != 0; i++) tick();
    user_r_rden = 0;
    tick();
    chk("drain_out_left", exp_out.size(), 0);
  endtask

  task automatic reopen();
    user_w_open = 0;
    user_r_open = 0;
    tick(2);
    chk("flush_ovf", ovf_err, 0);
    chk("flush_hls_rst", hls_rst, 1);
    user_w_open = 1;
    user_r_open = 1;
    tick(2);
    chk("open_hls_rst", hls_rst, 0);
  endtask

  initial begin
    #3 bus_rst_n = 0;
    #1 check_reset_vals("rst");
    #8 bus_rst_n = 1;
    user_w_open = 1;
    user_r_open = 1;
    tick(2);
    chk("open_hls_rst", hls_rst, 0);

    // Words 1..8 pass straight through to the core
    core_rd = 1;
    for (int i = 1; i <= 8; i++) begin
      user_w_wren = 1;
      user_w_data = W'(i);
      exp_in.push_back(W'(i));
      tick();
    end
    user_w_wren = 0;
    tick(4);
    chk("pass_left", exp_in.size(), 0);
    chk("pass_in_level", in_level, 0);
    chk("pass_in_empty_n", in_empty_n, 0);

    // Core loopback with randomized host write/read timing
    loop = 1;
    for (int sent = 0; sent < 1024;) begin
      user_r_rden = $urandom_range(3) != 0;
      user_w_wren = $urandom_range(1) == 1;
      if (user_w_wren) begin
        user_w_data = 32'hA5A5_0000 + W'(sent);
        exp_in.push_back(user_w_data);
        exp_out.push_back(user_w_data);
        sent++;
      end
      tick();
    end
    user_w_wren = 0;
    drain_out();
    chk("loop_in_left", exp_in.size(), 0);
    chk("loop_ovf", ovf_err, 0);
    loop = 0;
    core_rd = 0;

    // Input overflow: FIFO holds D words plus one in staging, next write is dropped
    for (int i = 0; i < D + 1; i++) begin
      user_w_wren = 1;
      user_w_data = 32'h1000 + W'(i);
      exp_in.push_back(user_w_data);
      tick();
    end
    chk("ifull_full", user_w_full, 1);
    chk("ifull_ovf_pre", ovf_err, 0);
    user_w_data = 32'hBAD0_BAD0;
    tick();
    user_w_wren = 0;
    chk("ifull_ovf", ovf_err, 1);
    chk("ifull_level", in_level, D);
    chk("ifull_stage_v", in_empty_n, 1);
    chk("ifull_stage_d", in_dout, 32'h1000);
    core_rd = 1;
    drain_in();
    core_rd = 0;
    chk("ifull_level_end", in_level, 0);
    chk("ifull_ovf_sticky", ovf_err, 1);
    reopen();

    // Output overflow and recovery after one host read
    for (int i = 0; i < D; i++) begin
      core_wr = 1;
      core_din = $urandom;
      exp_out.push_back(core_din);
      tick();
    end
    core_wr = 0;
    chk("ofull_level", out_level, D);
    chk("ofull_full_n", out_full_n, 0);
    chk("ofull_ovf_pre", ovf_err, 0);
    core_wr = 1;
    core_din = 32'hDEAD_BEEF;
    tick();
    core_wr = 0;
    chk("ofull_ovf", ovf_err, 1);
    chk("ofull_level_hold", out_level, D);
    user_r_rden = 1;
    tick();
    user_r_rden = 0;
    chk("ofull_full_n_after", out_full_n, 1);
    chk("ofull_level_after", out_level, D - 1);
    drain_out();
    reopen();

    // End of stream after write close, drain and host read-out
    loop = 1;
    core_rd = 1;
    for (int i = 0; i < 4; i++) begin
      user_w_wren = 1;
      user_w_data = $urandom;
      exp_in.push_back(user_w_data);
      exp_out.push_back(user_w_data);
      tick();
    end
    user_w_wren = 0;
    tick(6);
    user_w_open = 0;
    hls_idle = 1;
    tick(2);
    chk("eof_out_level", out_level, 4);
    chk("eof_early", user_r_eof, 0);
    user_r_rden = 1;
    tick(4);
    user_r_rden = 0;
    chk("eof_r_empty", user_r_empty, 1);
    chk("eof_not_yet", user_r_eof, 0);
    tick();
    chk("eof_set", user_r_eof, 1);
    chk("eof_out_left", exp_out.size(), 0);
    user_r_open = 0;
    tick();
    chk("eof_clear", user_r_eof, 0);
    chk("eof_hls_rst", hls_rst, 1);
    hls_idle = 0;
    loop = 0;
    core_rd = 0;

    // Asynchronous reset with 100 words buffered
    user_w_open = 1;
    user_r_open = 1;
    tick(2);
    for (int i = 0; i < 100; i++) begin
      user_w_wren = 1;
      user_w_data = $urandom;
      tick();
    end
    user_w_wren = 0;
    chk("mid_in_level", in_level, 99);
    #2 bus_rst_n = 0;
    #1 check_reset_vals("mid");
    exp_in.delete();
    exp_out.delete();
    #3 bus_rst_n = 1;
    tick(2);
    chk("post_in_level", in_level, 0);
    chk("post_out_level", out_level, 0);
    chk("post_in_empty_n", in_empty_n, 0);
    chk("post_hls_rst", hls_rst, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
